alert_handshake_rx: RTL and testbench

ALERT_HANDSHAKE_RX -- requirements
Module: alert_handshake_rx

---
 rtl/alert_handshake_rx_pkg.sv | 18 +
 rtl/prim_pkg.sv | 16 +
 rtl/alert_rx_sampler.sv | 44 ++++
 rtl/alert_handshake_rx.sv | 148 ++++++++++++++
 tb/tb_alert_handshake_rx.sv | 103 ++++++++++
 5 files changed

// File: rtl/alert_handshake_rx_pkg.sv
// Shared types and defaults for the alert handshake receiver.
package alert_handshake_rx_pkg;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    AckWait = 2'd1,
    Pause   = 2'd2
  } state_e;

  localparam int PingCntW           = 16;
  localparam int PauseCntW          = 4;
  localparam int PauseCyclesDefault = 2;
  localparam int PingTimeoutDefault = 255;

  // Quiescent (no alert) value of the differential alert pair.
  localparam prim_pkg::alert_tx_t AlertTxIdle = '{alert_p: 1'b0, alert_n: 1'b1};

endpackage

// File: rtl/prim_pkg.sv
// Differential wire types shared by alert senders and receivers.
package prim_pkg;

  typedef struct packed {
    logic alert_p;
    logic alert_n;
  } alert_tx_t;

  typedef struct packed {
    logic ping_p;
    logic ping_n;
    logic ack_p;
    logic ack_n;
  } alert_rx_t;

endpackage

// File: rtl/alert_rx_sampler.sv
// Input sampler for the alert pair: one register, or a 2-flop synchronizer
// when ALERT_RX_SYNC_EN is defined.
module alert_rx_sampler
  import prim_pkg::*;
  import alert_handshake_rx_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  alert_tx_t alert_tx_i,
  output alert_tx_t alert_tx_o
);

`ifdef ALERT_RX_SYNC_EN
  alert_tx_t sync_p0;
  alert_tx_t sample_p1;

  // p0: metastability capture, p1: stable sample
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0   <= AlertTxIdle;
      sample_p1 <= AlertTxIdle;
    end else begin
      sync_p0   <= alert_tx_i;
      sample_p1 <= sync_p0;
    end
  end

  assign alert_tx_o = sample_p1;
`else
  alert_tx_t sample_p0;

  // p0: single sample register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_p0 <= AlertTxIdle;
    end else begin
      sample_p0 <= alert_tx_i;
    end
  end

  assign alert_tx_o = sample_p0;
`endif

endmodule

// File: rtl/alert_handshake_rx.sv
// Alert receiver: acknowledges differential alerts, issues pings and checks
// pair integrity. ALERT_RX_SYNC_EN adds a synchronizer stage on the input.
module alert_handshake_rx
  import prim_pkg::*;
  import alert_handshake_rx_pkg::*;
#(
  parameter int PauseCycles = PauseCyclesDefault,
  parameter int PingTimeout = PingTimeoutDefault
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  alert_tx_t alert_tx_i,
  output alert_rx_t alert_rx_o,
  input  logic      ping_req_i,
  output logic      ping_ok_o,
  output logic      ping_fail_o,
  output logic      alert_o,
  output logic      integ_fail_o
);

  localparam logic [PauseCntW-1:0] PauseLast = PauseCntW'(PauseCycles - 1);
  localparam logic [PingCntW-1:0]  PingLimit = PingCntW'(PingTimeout);

  function automatic logic [PingCntW-1:0] sat_inc(input logic [PingCntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  alert_tx_t             tx_s;
  state_e                state_q, state_d;
  logic [PauseCntW-1:0]  pause_cnt_q, pause_cnt_d;
  logic [PingCntW-1:0]   ping_cnt_q, ping_cnt_d, ping_cnt_inc;
  logic                  ping_pend_q, ping_pend_d;
  logic                  ping_p_q, ping_p_d, ping_n_q, ping_n_d;
  logic                  alert_q, alert_d, ping_ok_q, ping_ok_d, ping_fail_q, ping_fail_d;
  logic                  integ_fail, tx_alert, tx_release, handshake;

  alert_rx_sampler u_sampler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alert_tx_i (alert_tx_i),
    .alert_tx_o (tx_s)
  );

  assign integ_fail   = (tx_s.alert_p == tx_s.alert_n);
  assign tx_alert     = tx_s.alert_p & ~tx_s.alert_n;
  assign tx_release   = ~tx_s.alert_p & tx_s.alert_n;
  assign ping_cnt_inc = sat_inc(ping_cnt_q);

  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    ping_pend_d = ping_pend_q;
    ping_cnt_d  = ping_cnt_q;
    ping_p_d    = ping_p_q;
    ping_n_d    = ping_n_q;
    alert_d     = 1'b0;
    ping_ok_d   = 1'b0;
    ping_fail_d = 1'b0;
    handshake   = 1'b0;

    if (integ_fail) begin
      state_d     = Idle;
      pause_cnt_d = '0;
    end else begin
      case (state_q)
        Idle: begin
          if (tx_alert) begin
            state_d   = AckWait;
            handshake = 1'b1;
          end
        end
        AckWait: begin
          if (tx_release) begin
            state_d     = Pause;
            pause_cnt_d = '0;
          end
        end
        Pause: begin
          // Alerts seen here are deliberately ignored until Idle is reached.
          if (pause_cnt_q == PauseLast) begin
            state_d = Idle;
          end else begin
            pause_cnt_d = pause_cnt_q + 1'b1;
          end
        end
        default: state_d = Idle;
      endcase
    end

    // A response on the timeout cycle takes priority over the failure.
    if (ping_pend_q) begin
      ping_cnt_d = ping_cnt_inc;
      if (handshake) begin
        ping_ok_d   = 1'b1;
        ping_pend_d = 1'b0;
        ping_cnt_d  = '0;
      end else if (ping_cnt_inc == PingLimit) begin
        ping_fail_d = 1'b1;
        ping_pend_d = 1'b0;
        ping_cnt_d  = '0;
      end
    end else begin
      alert_d = handshake;
      if (ping_req_i) begin
        ping_p_d    = ~ping_p_q;
        ping_n_d    = ~ping_n_q;
        ping_pend_d = 1'b1;
        ping_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      pause_cnt_q <= '0;
      ping_pend_q <= 1'b0;
      ping_cnt_q  <= '0;
      ping_p_q    <= 1'b0;
      ping_n_q    <= 1'b1;
      alert_q     <= 1'b0;
      ping_ok_q   <= 1'b0;
      ping_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
      ping_pend_q <= ping_pend_d;
      ping_cnt_q  <= ping_cnt_d;
      ping_p_q    <= ping_p_d;
      ping_n_q    <= ping_n_d;
      alert_q     <= alert_d;
      ping_ok_q   <= ping_ok_d;
      ping_fail_q <= ping_fail_d;
    end
  end

  // Ack is withdrawn immediately while the sampled pair is inconsistent.
  assign alert_rx_o.ack_p  = (state_q == AckWait) & ~integ_fail;
  assign alert_rx_o.ack_n  = ~alert_rx_o.ack_p;
  assign alert_rx_o.ping_p = ping_p_q;
  assign alert_rx_o.ping_n = ping_n_q;

  assign alert_o      = alert_q;
  assign ping_ok_o    = ping_ok_q;
  assign ping_fail_o  = ping_fail_q;
  assign integ_fail_o = integ_fail;

endmodule

// File: tb/tb_alert_handshake_rx.sv
// Directed bench for alert_handshake_rx (PauseCycles=2, PingTimeout=8).
module tb_alert_handshake_rx;
  import prim_pkg::*;

  logic      clk;
  logic      rst;
  alert_tx_t alert_tx;
  alert_rx_t alert_rx;
  logic      ping_req;
  logic      ping_ok;
  logic      ping_fail;
  logic      alert;
  logic      integ_fail;

  int n_checks = 0;
  int n_errors = 0;

  alert_handshake_rx #(
    .PauseCycles (2),
    .PingTimeout (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alert_tx_i   (alert_tx),
    .alert_rx_o   (alert_rx),
    .ping_req_i   (ping_req),
    .ping_ok_o    (ping_ok),
    .ping_fail_o  (ping_fail),
    .alert_o      (alert),
    .integ_fail_o (integ_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (alert ack_p ack_n ok fail ping_p ping_n integ)",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {alert, alert_rx.ack_p, alert_rx.ack_n, ping_ok, ping_fail,
            alert_rx.ping_p, alert_rx.ping_n, integ_fail};
  endfunction

  task automatic drive(input logic a, input logic bad, input logic req);
    alert_tx.alert_p = a | bad;
    alert_tx.alert_n = ~a | bad;
    ping_req         = req;
  endtask

  // Bit i of each mask is the input driven / output expected at negedge i.
  task automatic run(input string tag, input int len,
                     input logic [31:0] ap, input logic [31:0] bad, input logic [31:0] req,
                     input logic [31:0] e_al, input logic [31:0] e_ack, input logic [31:0] e_ok,
                     input logic [31:0] e_fail, input logic [31:0] e_pp, input logic [31:0] e_integ);
    drive(ap[0], bad[0], req[0]);
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      chk($sformatf("%s@%0d", tag, i), obs(),
          {e_al[i], e_ack[i], ~e_ack[i], e_ok[i], e_fail[i], e_pp[i], ~e_pp[i], e_integ[i]});
      drive(ap[i], bad[i], req[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_state", obs(), 8'h22);
    rst = 1'b0;

    //   tag          len  alert_in      bad    req     alert_o  ack_p   ping_ok fail        ping_p        integ
    run("plain",      16, 32'h3FF,      32'h0, 32'h0,   32'h4,   32'hFFC, 32'h0, 32'h0,      32'h0,        32'h0);
    run("pause",      14, 32'hF7,       32'h0, 32'h0,   32'h104, 32'h31C, 32'h0, 32'h0,      32'h0,        32'h0);
    run("ping_tmo",   22, 32'h0,        32'h0, 32'h801, 32'h0,   32'h0,   32'h0, 32'h100200, 32'hFFE,      32'h0);
    run("ping_ok",    16, 32'h3E0,      32'h0, 32'h1,   32'h0,   32'hF80, 32'h80, 32'h0,     32'hFFFFFFFE, 32'h0);
    run("integ",       8, 32'h7,        32'h8, 32'h0,   32'h4,   32'hC,   32'h0, 32'h0,      32'hFFFFFFFE, 32'h10);
    run("simult",     16, 32'h380,      32'h0, 32'h9,   32'h0,   32'hE00, 32'h200, 32'h0,    32'h0,        32'h0);

    // Reset while ack_p=1 with a ping pending
    run("pre_rst",     2, 32'h3,        32'h0, 32'h2,   32'h4,   32'h4,   32'h0, 32'h0,      32'h4,        32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset", obs(), 8'h22);
    rst = 1'b0;
    run("post_rst",   12, 32'h0,        32'h0, 32'h0,   32'h0,   32'h0,   32'h0, 32'h0,      32'h0,        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
